// File: rtl/snake_pkg.sv
// Shared constants for the snake game: one-hot direction codes, phase encodings
// and the helper that says which direction a move would reverse onto.
package snake_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam int NUM_BTN   = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_START = 4;

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_RUN  = 2'b01,
    PH_OVER = 2'b10,
    PH_BAD  = 2'b11
  } phase_e;

  function automatic logic [3:0] dir_opposite(input logic [3:0] d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/snake_input_ctrl_if.sv
// Button/game-core bundle around snake_input_ctrl; slave is the controller side.
interface snake_input_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_start;
  logic       game_over;
  logic [3:0] movement;
  logic       start;
  logic       dir_valid;
  logic [1:0] phase;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_start, game_over,
    input  movement, start, dir_valid, phase
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_start, game_over,
    output movement, start, dir_valid, phase
  );
endinterface

// File: rtl/snake_input_ctrl_btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and registered rising-edge
// detect. press_o is a single-cycle pulse one cycle after the level is accepted.
module btn_debounce #(
  parameter int DB_CYCLES = 250000,
  parameter int CNT_W     = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d, level_d1_q, press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) level_d = ~level_q;
      else                                cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
      press_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      level_d1_q <= level_q;
      press_q    <= level_q & ~level_d1_q;
      cnt_q      <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake front end: five debounced buttons feed a phase FSM that emits start
// pulses and a held one-hot movement code with 180-degree reversal rejection.
module snake_input_ctrl
  import snake_pkg::*;
#(
  parameter int DB_CYCLES = 250000,
  parameter int CNT_W     = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  snake_input_ctrl_if.slave    bus
);

  logic [NUM_BTN-1:0] raw, level, press;
  logic [3:0]         cand, mov_q;
  logic               accept, start_q, dv_q;
  phase_e             phase_q;

  assign raw = {bus.btn_start, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (raw[i]),
      .level_o (level[i]),
      .press_o (press[i])
    );
  end

  // Fixed priority up > down > left > right; losers of a tie are dropped.
  always_comb begin
    cand = DIR_NONE;
    if      (press[BTN_UP])    cand = DIR_UP;
    else if (press[BTN_DOWN])  cand = DIR_DOWN;
    else if (press[BTN_LEFT])  cand = DIR_LEFT;
    else if (press[BTN_RIGHT]) cand = DIR_RIGHT;
    accept = (cand != DIR_NONE) && (cand != mov_q) && (cand != dir_opposite(mov_q));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      mov_q   <= DIR_NONE;
      start_q <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      dv_q    <= 1'b0;
      case (phase_q)
        PH_IDLE, PH_OVER: begin
          // Start outranks any simultaneous direction; dir_valid marks the clear.
          if (press[BTN_START]) begin
            start_q <= 1'b1;
            mov_q   <= DIR_NONE;
            dv_q    <= (mov_q != DIR_NONE);
            phase_q <= PH_RUN;
          end
        end
        PH_RUN: begin
          if (accept) begin
            mov_q <= cand;
            dv_q  <= 1'b1;
          end
          if (bus.game_over) phase_q <= PH_OVER;
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  assign bus.movement  = mov_q;
  assign bus.start     = start_q;
  assign bus.dir_valid = dv_q;
  assign bus.phase     = phase_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DB_CYCLES=4 (press-to-output latency 7).
module tb_snake_input_ctrl;

  localparam int DB = 4;
  localparam int LAT = DB + 3;

  typedef struct {
    int         cyc;
    logic [3:0] mov;
    logic       st;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] btn = '0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         rp_cnt = 0;
  exp_t       sb[$];

  snake_input_ctrl_if bus ();

  assign bus.btn_up    = btn[0];
  assign bus.btn_down  = btn[1];
  assign bus.btn_left  = btn[2];
  assign bus.btn_right = btn[3];
  assign bus.btn_start = btn[4];

  snake_input_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every start/dir_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && (bus.start || bus.dir_valid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {bus.movement, bus.start, bus.dir_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_movement", bus.movement, e.mov);
        chk("pulse_start", bus.start, e.st);
        if (!e.st) chk("pulse_dir_valid", bus.dir_valid, 1'b1);
      end
    end
    if (dut.g_btn[3].u_db.press_o) rp_cnt++;
  end

  task automatic expect_evt(input logic [3:0] mov, input logic st);
    exp_t e;
    e.cyc = cyc + 1 + LAT;
    e.mov = mov;
    e.st  = st;
    sb.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input int n);
    btn[b] = 1'b1;
    hold(n);
    btn[b] = 1'b0;
    hold(14);
  endtask

  initial begin
    // 1: reset with all buttons high, then start press
    reset = 1'b0;
    btn   = 5'b11111;
    hold(2);
    chk("rst_movement", bus.movement, 4'b0000);
    chk("rst_start", bus.start, 1'b0);
    chk("rst_dir_valid", bus.dir_valid, 1'b0);
    chk("rst_phase", bus.phase, 2'b00);
    btn   = '0;
    reset = 1'b1;
    expect_evt(4'b0000, 1'b1);
    press(4, 10);
    chk("run_phase", bus.phase, 2'b01);
    chk("start_movement", bus.movement, 4'b0000);

    // 2: glitch, accepted up, rejected reversal
    press(0, 3);
    chk("glitch_movement", bus.movement, 4'b0000);
    expect_evt(4'b0001, 1'b0);
    press(0, 10);
    chk("up_movement", bus.movement, 4'b0001);
    press(1, 10);
    chk("down_reject", bus.movement, 4'b0001);

    // 3: right accepted, repeat ignored, left reversal rejected
    expect_evt(4'b1000, 1'b0);
    press(3, 10);
    chk("right_movement", bus.movement, 4'b1000);
    press(3, 10);
    chk("right_repeat", bus.movement, 4'b1000);
    press(2, 10);
    chk("left_reject", bus.movement, 4'b1000);

    // 4: down and left together, down wins
    expect_evt(4'b0010, 1'b0);
    btn[1] = 1'b1;
    btn[2] = 1'b1;
    hold(10);
    btn[1] = 1'b0;
    btn[2] = 1'b0;
    hold(14);
    chk("tie_movement", bus.movement, 4'b0010);

    // 5: game over freezes, start restarts
    bus.game_over = 1'b1;
    hold(1);
    chk("over_phase", bus.phase, 2'b10);
    press(0, 10);
    chk("over_frozen", bus.movement, 4'b0010);
    bus.game_over = 1'b0;
    expect_evt(4'b0000, 1'b1);
    press(4, 10);
    chk("restart_phase", bus.phase, 2'b01);
    chk("restart_movement", bus.movement, 4'b0000);

    // 6: reset mid-debounce with right held, then full re-qualification
    rp_cnt = 0;
    btn[3] = 1'b1;
    hold(4);
    chk("mid_cnt", dut.g_btn[3].u_db.cnt_q, 3'd2);
    reset = 1'b0;
    hold(1);
    chk("rst2_phase", bus.phase, 2'b00);
    chk("rst2_movement", bus.movement, 4'b0000);
    chk("rst2_cnt", dut.g_btn[3].u_db.cnt_q, 3'd0);
    chk("rst2_sync", dut.g_btn[3].u_db.sync2_q, 1'b0);
    reset = 1'b1;
    hold(LAT - 1);
    chk("requal_early", rp_cnt, 0);
    hold(8);
    chk("requal_press_count", rp_cnt, 1);
    chk("requal_movement", bus.movement, 4'b0000);
    chk("requal_phase", bus.phase, 2'b00);
    btn[3] = 1'b0;
    hold(4);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial bus.game_over = 1'b0;

endmodule
